// File: rtl/calc_pkg.sv
// Calculator shared types: button codes, raw bus and sequencer states.
// Also hosts the code-to-bus mapping used by the sequencer and DV.
package calc_pkg;

  typedef enum logic [4:0] {
    B_NONE  = 5'd0,
    B_NUM_0 = 5'd1,
    B_NUM_1 = 5'd2,
    B_NUM_2 = 5'd3,
    B_NUM_3 = 5'd4,
    B_NUM_4 = 5'd5,
    B_NUM_5 = 5'd6,
    B_NUM_6 = 5'd7,
    B_NUM_7 = 5'd8,
    B_NUM_8 = 5'd9,
    B_NUM_9 = 5'd10,
    B_PLUS  = 5'd11,
    B_MINUS = 5'd12,
    B_MUL   = 5'd13,
    B_DIV   = 5'd14,
    B_EQ    = 5'd15,
    B_CLR   = 5'd16
  } active_button_t;

  localparam int unsigned NumButtons = 16;

  typedef logic [NumButtons-1:0] buttons_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PRESS,
    S_SETTLE,
    S_WAIT
  } seq_state_e;

  // Code n drives bit n-1; B_NONE maps to an all-zero bus.
  function automatic buttons_t button2buttons(
    input active_button_t b
  );
    logic [NumButtons:0] w;
    w = {{NumButtons{1'b0}}, 1'b1} << b;
    return w[NumButtons:1];
  endfunction

endpackage

// File: rtl/button_fifo.sv
// Small power-of-two FIFO with flush, generic over element type.
// Flush wins over push and pop in the same cycle.
module button_fifo #(
  parameter int unsigned Depth = 8,
  parameter type         T     = logic [7:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: cnt_q <= cnt_q + 1'b1;
        do_pop && !do_push: cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/button_sequencer.sv
// Replays queued button codes as clean gap/hold/settle presses,
// waiting for the controller to go idle between entries.
module button_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned Depth        = 8,
  parameter int unsigned GapCycles    = 1,
  parameter int unsigned HoldCycles   = 2,
  parameter int unsigned SettleCycles = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_valid_i,
  input  active_button_t             push_button_i,
  output logic                       push_ready_o,
  input  logic                       flush_i,
  input  logic                       ctrl_idle_i,
  output buttons_t                   buttons_o,
  output logic                       busy_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       done_o
);

  localparam int unsigned MaxGH =
    (GapCycles > HoldCycles) ? GapCycles : HoldCycles;
  localparam int unsigned MaxCyc =
    (MaxGH > SettleCycles) ? MaxGH : SettleCycles;
  localparam int unsigned CntW =
    (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  seq_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  buttons_t       buttons_q;

  active_button_t head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  assign pop = (state_q == S_WAIT) && ctrl_idle_i;

  button_fifo #(
    .Depth (Depth),
    .T     (active_button_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_valid_i),
    .data_i  (push_button_i),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign push_ready_o = !fifo_full;
  assign busy_o       = (state_q != S_IDLE) || !fifo_empty;
  assign buttons_o    = buttons_q;
  assign done_o       = rst_ni && !flush_i && pop && !fifo_empty;

  // buttons_q is loaded with the value of the state being entered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      buttons_q <= '0;
    end else begin
      buttons_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty && ctrl_idle_i) begin
            state_q <= S_GAP;
            cnt_q   <= CntW'(GapCycles - 1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q   <= S_PRESS;
            cnt_q     <= CntW'(HoldCycles - 1);
            buttons_q <= button2buttons(head);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PRESS: begin
          if (cnt_q == '0) begin
            state_q <= S_SETTLE;
            cnt_q   <= CntW'(SettleCycles - 1);
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            buttons_q <= button2buttons(head);
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (ctrl_idle_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_sequencer.sv
// Directed bench for button_sequencer: vector table plus
// hand-written backpressure, wrap, flush, reset and delay cases.
module tb_button_sequencer;
  import calc_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           push_valid = 1'b0;
  active_button_t push_button = B_NONE;
  logic           flush = 1'b0;
  logic           ctrl_idle = 1'b0;
  logic           push_ready;
  buttons_t       buttons;
  logic           busy;
  logic [3:0]     count;
  logic           done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .push_valid_i  (push_valid),
    .push_button_i (push_button),
    .push_ready_o  (push_ready),
    .flush_i       (flush),
    .ctrl_idle_i   (ctrl_idle),
    .buttons_o     (buttons),
    .busy_o        (busy),
    .count_o       (count),
    .done_o        (done)
  );

  typedef struct {
    logic           pv;
    active_button_t pb;
    logic           idle;
    logic           fl;
    buttons_t       eb;
    logic           ed;
    logic [3:0]     ec;
    logic           er;
    logic           ebusy;
  } vec_t;

  vec_t           tv [10];
  active_button_t seq [12];
  buttons_t       exp_oh [12];
  buttons_t       cap [12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn,
                       input logic pv,
                       input active_button_t pb,
                       input logic idle,
                       input logic fl);
    @(negedge clk);
    rst_n       = rn;
    push_valid  = pv;
    push_button = pb;
    ctrl_idle   = idle;
    flush       = fl;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, B_NONE, 1'b0, 1'b0);
    drive(1'b0, 1'b0, B_NONE, 1'b0, 1'b0);
  endtask

  initial begin
    // Basic timing, one B_NUM_1 press with the controller idle.
    tv[0] = '{1'b1, B_NUM_1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};
    tv[1] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[2] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[3] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0002, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[4] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0002, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[5] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[6] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b1};
    tv[7] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b1, 4'd1, 1'b1, 1'b1};
    tv[8] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};
    tv[9] = '{1'b0, B_NONE,  1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b1, 1'b0};

    seq = '{B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4, B_NUM_5, B_NUM_6,
            B_NUM_7, B_NUM_8, B_NUM_9, B_PLUS, B_MINUS, B_MUL};
    exp_oh = '{16'h0002, 16'h0004, 16'h0008, 16'h0010,
               16'h0020, 16'h0040, 16'h0080, 16'h0100,
               16'h0200, 16'h0400, 16'h0800, 16'h1000};

    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, tv[c].pv, tv[c].pb, tv[c].idle, tv[c].fl);
      check($sformatf("tbl buttons c%0d", c), 32'(buttons), 32'(tv[c].eb));
      check($sformatf("tbl done c%0d", c), 32'(done), 32'(tv[c].ed));
      check($sformatf("tbl count c%0d", c), 32'(count), 32'(tv[c].ec));
      check($sformatf("tbl ready c%0d", c), 32'(push_ready), 32'(tv[c].er));
      check($sformatf("tbl busy c%0d", c), 32'(busy), 32'(tv[c].ebusy));
    end

    // Backpressure: idle low for 20 cycles while waiting.
    do_reset();
    drive(1'b1, 1'b1, B_NUM_2, 1'b1, 1'b0);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    for (int c = 2; c < 7; c++) begin
      drive(1'b1, 1'b0, B_NONE, 1'b0, 1'b0);
      if (c == 3 || c == 4)
        check($sformatf("bp press c%0d", c), 32'(buttons), 32'h0004);
    end
    for (int c = 7; c < 27; c++) begin
      drive(1'b1, 1'b0, B_NONE, 1'b0, 1'b0);
      check($sformatf("bp buttons c%0d", c), 32'(buttons), 32'h0);
      check($sformatf("bp done c%0d", c), 32'(done), 32'h0);
    end
    check("bp count held", 32'(count), 32'd1);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("bp done on idle", 32'(done), 32'd1);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("bp done after", 32'(done), 32'd0);
    check("bp count after", 32'(count), 32'd0);
    check("bp busy after", 32'(busy), 32'd0);

    // Full and pointer wrap.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, seq[k], 1'b0, 1'b0);
      check($sformatf("full count k%0d", k), 32'(count), 32'(k));
      check($sformatf("full ready k%0d", k), 32'(push_ready),
            (k < 8) ? 32'd1 : 32'd0);
    end
    begin
      int             nxt;
      int             ncap;
      int             width;
      buttons_t       prev;
      active_button_t pb;
      logic           pv;
      nxt   = 8;
      ncap  = 0;
      width = 0;
      prev  = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        pv = (nxt < 12);
        pb = B_NONE;
        if (nxt < 12) pb = seq[nxt];
        drive(1'b1, pv, pb, 1'b1, 1'b0);
        if (pv && push_ready) nxt++;
        if (buttons != '0) width++;
        if (buttons != '0 && prev == '0 && ncap < 12) begin
          cap[ncap] = buttons;
          ncap++;
        end
        prev = buttons;
        if (nxt == 12 && ncap == 12 && !busy) break;
      end
      check("wrap pushes", 32'(nxt), 32'd12);
      check("wrap presses", 32'(ncap), 32'd12);
      check("wrap width", 32'(width), 32'd24);
      for (int i = 0; i < ncap; i++)
        check($sformatf("wrap order %0d", i), 32'(cap[i]), 32'(exp_oh[i]));
    end

    // Flush in the second press cycle, with a push at the same time.
    do_reset();
    drive(1'b1, 1'b1, B_NUM_1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, B_NUM_2, 1'b1, 1'b0);
    drive(1'b1, 1'b1, B_NUM_3, 1'b1, 1'b0);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("fl press c3", 32'(buttons), 32'h0002);
    check("fl count c3", 32'(count), 32'd3);
    drive(1'b1, 1'b1, B_NUM_4, 1'b1, 1'b1);
    check("fl press c4", 32'(buttons), 32'h0002);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("fl buttons", 32'(buttons), 32'h0);
    check("fl count", 32'(count), 32'd0);
    check("fl done", 32'(done), 32'd0);
    check("fl busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("fl count later", 32'(count), 32'd0);

    // Same again with reset instead of flush.
    do_reset();
    drive(1'b1, 1'b1, B_NUM_1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, B_NUM_2, 1'b1, 1'b0);
    drive(1'b1, 1'b1, B_NUM_3, 1'b1, 1'b0);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    drive(1'b0, 1'b1, B_NUM_4, 1'b1, 1'b0);
    check("rs press c4", 32'(buttons), 32'h0002);
    drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
    check("rs buttons", 32'(buttons), 32'h0);
    check("rs count", 32'(count), 32'd0);
    check("rs done", 32'(done), 32'd0);
    check("rs busy", 32'(busy), 32'd0);
    check("rs ready", 32'(push_ready), 32'd1);

    // B_NONE acts as a scripted delay ahead of B_NUM_3.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c == 0)
        drive(1'b1, 1'b1, B_NONE, 1'b1, 1'b0);
      else if (c == 1)
        drive(1'b1, 1'b1, B_NUM_3, 1'b1, 1'b0);
      else
        drive(1'b1, 1'b0, B_NONE, 1'b1, 1'b0);
      check($sformatf("dly buttons c%0d", c), 32'(buttons),
            (c == 10 || c == 11) ? 32'h0008 : 32'h0);
      check($sformatf("dly done c%0d", c), 32'(done),
            (c == 7 || c == 14) ? 32'd1 : 32'd0);
      if (c == 8) check("dly count c8", 32'(count), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
